// File: rtl/y86_pkg.sv
// Shared definitions for the sequential Y86-64 control path.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_PCUPD,
        ST_HALT
    } state_t;

    function automatic logic is_mem_icode(input logic [3:0] ic);
        logic r;
        case (ic)
            IRMMOVQ, IMRMOVQ, ICALL,
            IRET, IPUSHQ, IPOPQ: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/y86_seq_ctrl_mem_wait_timer.sv
// Counts data-memory wait cycles; flags the cycle that would be the
// MEM_TIMEOUT-th consecutive wait so the FSM can give up on it.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_wait,
    output logic o_timeout
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] r_cnt;

    assign o_timeout = i_wait && (r_cnt == W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_wait && !o_timeout) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/y86_seq_ctrl.sv
// Stage sequencer for the sequential Y86-64 core: one-hot stage strobes,
// PC register, data-memory handshake with timeout, status and counters.
module y86_seq_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          CNT_W       = 32,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic [63:0]      pcnxt,
    input  logic             dmem_ack,
    input  logic             dmem_error,
    output logic [63:0]      pc,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic             dmem_req,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    import y86_pkg::*;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [63:0]      r_pc;
    logic [2:0]       r_stat;
    logic [2:0]       w_stat_nxt;
    logic [3:0]       r_icode;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             w_mem_req;
    logic             w_mem_wait;
    logic             w_timeout;
    logic             w_active;

    // Request is a pure function of state so reset drops it immediately.
    assign w_mem_req  = (r_state == ST_MEMORY) && is_mem_icode(r_icode);
    assign w_mem_wait = w_mem_req && !dmem_ack;
    assign w_active   = fetch_en | decode_en | exec_en
                      | mem_en | wb_en | pc_en;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (r_state != ST_MEMORY),
        .i_wait   (w_mem_wait),
        .o_timeout(w_timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stat_nxt  = r_stat;
        fetch_en    = 1'b0;
        decode_en   = 1'b0;
        exec_en     = 1'b0;
        mem_en      = 1'b0;
        wb_en       = 1'b0;
        pc_en       = 1'b0;
        halted      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                fetch_en = 1'b1;
                if (imem_error) begin
                    w_stat_nxt  = SADR;
                    w_state_nxt = ST_HALT;
                end else if (!instr_valid) begin
                    w_stat_nxt  = SINS;
                    w_state_nxt = ST_HALT;
                end else if (icode == IHALT) begin
                    w_stat_nxt  = SHLT;
                    w_state_nxt = ST_HALT;
                end else begin
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                decode_en   = 1'b1;
                w_state_nxt = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                exec_en     = 1'b1;
                w_state_nxt = ST_MEMORY;
            end
            ST_MEMORY: begin
                mem_en = 1'b1;
                if (!w_mem_req) begin
                    w_state_nxt = ST_WRITEBACK;
                end else if (dmem_ack) begin
                    // An ack in the timeout cycle still completes the access.
                    if (dmem_error) begin
                        w_stat_nxt  = SADR;
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_state_nxt = ST_WRITEBACK;
                    end
                end else if (w_timeout) begin
                    w_stat_nxt  = SADR;
                    w_state_nxt = ST_HALT;
                end
            end
            ST_WRITEBACK: begin
                wb_en       = 1'b1;
                w_state_nxt = ST_PCUPD;
            end
            ST_PCUPD: begin
                pc_en       = 1'b1;
                w_state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_stat      <= SAOK;
            r_icode     <= 4'h0;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_stat <= w_stat_nxt;
            if (fetch_en) r_icode <= icode;
            if (pc_en) begin
                r_pc        <= pcnxt;
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
            if (w_active) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    assign pc        = r_pc;
    assign stat      = r_stat;
    assign dmem_req  = w_mem_req;
    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Directed bench for y86_seq_ctrl: vector table of single-instruction runs
// plus hand sequences for strobe order, halt absorption and async reset.
module tb_y86_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  icode;
    logic        instr_valid;
    logic        imem_error;
    logic [63:0] pcnxt;
    logic        dmem_ack;
    logic        dmem_error;
    logic [63:0] pc;
    logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en;
    logic        dmem_req;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
    logic [5:0]  strb;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign strb = {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en};

    y86_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .icode      (icode),
        .instr_valid(instr_valid),
        .imem_error (imem_error),
        .pcnxt      (pcnxt),
        .dmem_ack   (dmem_ack),
        .dmem_error (dmem_error),
        .pc         (pc),
        .fetch_en   (fetch_en),
        .decode_en  (decode_en),
        .exec_en    (exec_en),
        .mem_en     (mem_en),
        .wb_en      (wb_en),
        .pc_en      (pc_en),
        .dmem_req   (dmem_req),
        .stat       (stat),
        .halted     (halted),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    typedef struct {
        logic [3:0]  ic;
        logic        vld;
        logic        imerr;
        logic [63:0] nxt;
        int          ack_at;
        logic        derr;
        logic [2:0]  e_stat;
        logic        e_halt;
        logic [63:0] e_pc;
        int          e_icnt;
        int          e_ccnt;
        int          e_waits;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0;
        dmem_ack = 1'b0; dmem_error = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic run_one(input int idx, input vec_t v);
        int  waits = 0;
        int  guard = 0;
        bit  done  = 0;
        bit  was_pc;
        string tag;
        tag = $sformatf("v%0d", idx);
        do_reset();
        icode = v.ic; instr_valid = v.vld;
        imem_error = v.imerr; pcnxt = v.nxt;
        start = 1'b1;
        step();
        start = 1'b0;
        while (!done) begin
            if (guard >= 60) begin
                $display("FAIL %s_timeout: got no retire/halt expected one", tag);
                n_total++;
                break;
            end
            if (halted) begin
                done = 1;
            end else begin
                dmem_ack = 1'b0; dmem_error = 1'b0;
                if (dmem_req) begin
                    if (waits == v.ack_at) begin
                        dmem_ack = 1'b1; dmem_error = v.derr;
                    end else begin
                        waits++;
                    end
                end
                was_pc = pc_en;
                step();
                guard++;
                if (was_pc) done = 1;
            end
        end
        dmem_ack = 1'b0; dmem_error = 1'b0;
        chk({tag, "_stat"},   64'(stat),      64'(v.e_stat));
        chk({tag, "_halted"}, 64'(halted),    64'(v.e_halt));
        chk({tag, "_pc"},     pc,             v.e_pc);
        chk({tag, "_icnt"},   64'(instr_cnt), 64'(v.e_icnt));
        chk({tag, "_ccnt"},   64'(cycle_cnt), 64'(v.e_ccnt));
        chk({tag, "_waits"},  64'(waits),     64'(v.e_waits));
    endtask

    initial begin
        logic [5:0] seq [6];
        logic [31:0] ccnt_h;

        // ic vld imerr nxt ack derr | stat halt pc icnt ccnt waits
        vecs[0] = '{4'h3, 1'b1, 1'b0, 64'h10, 99, 1'b0, 3'd1, 1'b0, 64'h10, 1, 6, 0};
        vecs[1] = '{4'h5, 1'b1, 1'b0, 64'h20, 3,  1'b0, 3'd1, 1'b0, 64'h20, 1, 9, 3};
        vecs[2] = '{4'h4, 1'b1, 1'b0, 64'h30, 0,  1'b0, 3'd1, 1'b0, 64'h30, 1, 6, 0};
        vecs[3] = '{4'h0, 1'b1, 1'b0, 64'h50, 99, 1'b0, 3'd2, 1'b1, 64'h0,  0, 1, 0};
        vecs[4] = '{4'h3, 1'b0, 1'b0, 64'h50, 99, 1'b0, 3'd4, 1'b1, 64'h0,  0, 1, 0};
        vecs[5] = '{4'h3, 1'b0, 1'b1, 64'h50, 99, 1'b0, 3'd3, 1'b1, 64'h0,  0, 1, 0};
        vecs[6] = '{4'h8, 1'b1, 1'b0, 64'h50, 99, 1'b0, 3'd3, 1'b1, 64'h0,  0, 19, 16};
        vecs[7] = '{4'h9, 1'b1, 1'b0, 64'h40, 15, 1'b0, 3'd1, 1'b0, 64'h40, 1, 21, 15};
        vecs[8] = '{4'hB, 1'b1, 1'b0, 64'h50, 2,  1'b1, 3'd3, 1'b1, 64'h0,  0, 6, 2};
        vecs[9] = '{4'h6, 1'b1, 1'b0, 64'h2,  99, 1'b0, 3'd1, 1'b0, 64'h2,  1, 6, 0};

        seq[0] = 6'b100000; seq[1] = 6'b010000; seq[2] = 6'b001000;
        seq[3] = 6'b000100; seq[4] = 6'b000010; seq[5] = 6'b000001;

        icode = 4'h3; instr_valid = 1'b1; imem_error = 1'b0;
        pcnxt = 64'h0; start = 1'b0;
        dmem_ack = 1'b0; dmem_error = 1'b0;

        // Reset state while rst is held
        rst = 1'b1;
        step();
        chk("rst_pc",     pc,              64'h0);
        chk("rst_stat",   64'(stat),       64'd1);
        chk("rst_strb",   64'(strb),       64'd0);
        chk("rst_req",    64'(dmem_req),   64'd0);
        chk("rst_halted", 64'(halted),     64'd0);
        chk("rst_ccnt",   64'(cycle_cnt),  64'd0);
        rst = 1'b0;
        step();
        chk("idle_strb", 64'(strb), 64'd0);

        // Strobe order; stray ack/error on a non-memory op is ignored
        pcnxt = 64'h18; dmem_ack = 1'b1; dmem_error = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("seq_strb%0d", i), 64'(strb), 64'(seq[i]));
            chk($sformatf("seq_req%0d", i), 64'(dmem_req), 64'd0);
            step();
        end
        chk("seq_fetch2", 64'(fetch_en),  64'd1);
        chk("seq_stat",   64'(stat),      64'd1);
        chk("seq_pc",     pc,             64'h18);
        chk("seq_icnt",   64'(instr_cnt), 64'd1);
        chk("seq_ccnt",   64'(cycle_cnt), 64'd6);

        // Second instruction is a load; reset it mid-MEMORY
        icode = 4'h5; dmem_ack = 1'b0; dmem_error = 1'b0;
        step(); step(); step();
        chk("mrst_mem_en", 64'(mem_en),   64'd1);
        chk("mrst_req_hi", 64'(dmem_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_req",  64'(dmem_req),  64'd0);
        chk("mrst_strb", 64'(strb),      64'd0);
        chk("mrst_pc",   pc,             64'h0);
        chk("mrst_icnt", 64'(instr_cnt), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("mrst_idle", 64'(strb), 64'd0);

        // Vector table
        for (int k = 0; k < 10; k++) run_one(k, vecs[k]);

        // HALT is absorbing: start and stray acks change nothing
        do_reset();
        icode = 4'h0; instr_valid = 1'b1; pcnxt = 64'h77;
        start = 1'b1;
        step(); step();
        ccnt_h = cycle_cnt;
        icode = 4'h3; dmem_ack = 1'b1;
        for (int i = 0; i < 5; i++) step();
        start = 1'b0; dmem_ack = 1'b0;
        chk("habs_halted", 64'(halted),    64'd1);
        chk("habs_stat",   64'(stat),      64'd2);
        chk("habs_pc",     pc,             64'h0);
        chk("habs_ccnt",   64'(cycle_cnt), 64'(ccnt_h));
        chk("habs_ccnt1",  64'(cycle_cnt), 64'd1);
        chk("habs_strb",   64'(strb),      64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
